ifetch_queue_unit: RTL and testbench

Instruction-fetch front end for the pipelined MIPS core, replacing the single-register PC plus next-PC mux of the single-cycle datapath. It holds the PC and preserves the PC[31] kernel bit across PC+4. It fetches from the combinational instruction memory into a parametrised fetch queue with a valid/ready handshake toward decode. It accepts redirects (branch, jump, jr, exception) from EX and handles IRQ entry with a precise return address.

---
 rtl/ifetch_queue_unit.sv | 149 ++++++++++++++
 tb/tb_ifetch_queue_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue_unit.sv
// Instruction-fetch front end: PC register, kernel-bit-preserving PC+4, fetch queue toward decode, redirect/exception/IRQ entry.
// Latency: one cycle from fetch to id_* (zero cycles when FQ_BYPASS_EN is defined and the queue is empty).
// Backpressure: fetch stalls (PC holds) while the queue is full and decode does not pop; optional feature macro FQ_BYPASS_EN.
module ifetch_queue_unit #(
    parameter int          FQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [31:0]               imem_addr,
    input  logic [31:0]               imem_data,
    output logic                      id_valid,
    input  logic                      id_ready,
    output logic [31:0]               id_instr,
    output logic [31:0]               id_pc,
    output logic [31:0]               id_pcplus4,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    input  logic                      exc_req,
    input  logic                      irq,
    output logic                      irq_take,
    output logic [31:0]               epc,
    output logic [$clog2(FQ_DEPTH):0] fq_count
);

    localparam int            PW       = $clog2(FQ_DEPTH);
    localparam int            CW       = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FQ_DEPTH);

    // PC+4 within the current segment: bit 31 (kernel bit) never changes.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

    logic [31:0]   r_fq_pc    [FQ_DEPTH];
    logic [31:0]   r_fq_instr [FQ_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_pc;
    logic [31:0]   r_epc;
    logic          r_irq_take;

    logic          w_empty;
    logic          w_full;
    logic [31:0]   w_head_pc;
    logic [31:0]   w_head_instr;
    logic [31:0]   w_oldest_pc;
    logic          w_irq_take;
    logic          w_ctrl;
    logic          w_bypass;
    logic          w_hs;
    logic          w_q_pop;
    logic          w_byp_use;
    logic          w_fetch;
    logic          w_push;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == FULL_CNT);
    assign w_head_pc    = r_fq_pc[r_rd_ptr];
    assign w_head_instr = r_fq_instr[r_rd_ptr];

    // The instruction an interrupt would pre-empt: queue head, or the PC being fetched if nothing is queued.
    assign w_oldest_pc  = w_empty ? r_pc : w_head_pc;
    assign w_irq_take   = irq && !redirect_valid && !exc_req && !w_oldest_pc[31];

    // Any control transfer this cycle suppresses normal push/pop.
    assign w_ctrl       = exc_req || redirect_valid || w_irq_take;

`ifdef FQ_BYPASS_EN
    // Empty queue: present the word being fetched directly to decode.
    assign w_bypass     = w_empty && !w_ctrl;
`else
    assign w_bypass     = 1'b0;
`endif

    assign id_valid     = !w_empty || w_bypass;
    assign id_pc        = w_bypass ? r_pc : w_head_pc;
    assign id_instr     = w_bypass ? imem_data : w_head_instr;
    assign id_pcplus4   = pc_inc(id_pc);

    // A handshake only counts when no control transfer discards it.
    assign w_hs         = id_valid && id_ready && !w_ctrl;
    assign w_q_pop      = w_hs && !w_empty;
    assign w_byp_use    = w_hs && w_bypass;
    // Fetch proceeds when a slot is free now or is freed by this cycle's pop.
    assign w_fetch      = !w_ctrl && (!w_full || w_q_pop);
    assign w_push       = w_fetch && !w_byp_use;

    assign imem_addr    = r_pc;
    assign epc          = r_epc;
    assign irq_take     = r_irq_take;
    assign fq_count     = r_count;

    // Queue storage: write the fetched {PC, word} at the tail; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fq_pc[r_wr_ptr]    <= r_pc;
            r_fq_instr[r_wr_ptr] <= imem_data;
        end
    end

    // PC, queue pointers/occupancy, EPC and IRQ pulse, with reset > exc > redirect > irq > fetch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_epc      <= '0;
            r_irq_take <= 1'b0;
        end else begin
            r_irq_take <= 1'b0;
            if (w_ctrl) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end
            if (exc_req) begin
                r_pc  <= EXC_VEC;
                r_epc <= redirect_pc;
            end else if (redirect_valid) begin
                r_pc  <= redirect_pc;
            end else if (w_irq_take) begin
                r_pc       <= IRQ_VEC;
                r_epc      <= w_oldest_pc;
                r_irq_take <= 1'b1;
            end else begin
                if (w_fetch) begin
                    r_pc <= pc_inc(r_pc);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_q_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                case ({w_push, w_q_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifetch_queue_unit.sv
// Bench for ifetch_queue_unit: cycle table of control inputs with expected state, then a streamed run
// where expected fetch PCs are queued up front and matched against each decode handshake.
// Instruction memory returns the bitwise inverse of the address so instr and PC are distinguishable.
module tb_ifetch_queue_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pcplus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_req;
    logic        irq;
    logic        irq_take;
    logic [31:0] epc;
    logic [2:0]  fq_count;

    localparam logic [31:0] NOCHK = 32'h0000_0001;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        exc;
        logic        irq;
        logic [31:0] pc;
        int          cnt;
        logic        vld;
        logic        take;
        logic [31:0] epc;
        logic [31:0] hpc;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    assign imem_data = ~imem_addr;

    ifetch_queue_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pcplus4     (id_pcplus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_req        (exc_req),
        .irq            (irq),
        .irq_take       (irq_take),
        .epc            (epc),
        .fq_count       (fq_count)
    );

    function automatic logic [31:0] pc4(input logic [31:0] p);
        return {p[31], p[30:0] + 31'd4};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
        end
    endtask

    task automatic row(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic exc, input logic irq_i, input logic [31:0] pc, input int cnt,
                       input logic vld, input logic take, input logic [31:0] epc_e, input logic [31:0] hpc);
        vec_t v;
        v.rst_n = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.exc = exc; v.irq = irq_i;
        v.pc = pc; v.cnt = cnt; v.vld = vld; v.take = take; v.epc = epc_e; v.hpc = hpc;
        tbl.push_back(v);
    endtask

    // Random decode backpressure; every handshake must deliver the next queued expected PC.
    task automatic sb_run(input int maxc);
        int          c;
        logic [31:0] e;
        c = 0;
        while (sb_q.size() != 0 && c < maxc) begin
            @(posedge clk);
            #1;
            id_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (id_valid && id_ready) begin
                e = sb_q.pop_front();
                chk("sb_pc", id_pc, e);
                chk("sb_instr", id_instr, ~e);
            end
            c++;
        end
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        exc_req = 1'b0; irq = 1'b0;

        //  rst rdy rv  rpc            exc irq  pc            cnt vld take epc           head pc
        row(0, 0, 0, 32'h0,          0, 0, 32'h80000000, 0, 0, 0, 32'h0,        NOCHK);
        row(1, 1, 0, 32'h0,          0, 0, 32'h80000004, 1, 1, 0, 32'h0,        32'h80000000);
        row(1, 1, 0, 32'h0,          0, 0, 32'h80000008, 1, 1, 0, 32'h0,        32'h80000004);
        row(1, 1, 0, 32'h0,          0, 0, 32'h8000000C, 1, 1, 0, 32'h0,        32'h80000008);
        // stall decode: queue fills to 4, PC stops at RESET_PC+16
        row(0, 0, 0, 32'h0,          0, 0, 32'h80000000, 0, 0, 0, 32'h0,        NOCHK);
        row(1, 0, 0, 32'h0,          0, 0, 32'h80000004, 1, 1, 0, 32'h0,        32'h80000000);
        row(1, 0, 0, 32'h0,          0, 0, 32'h80000008, 2, 1, 0, 32'h0,        32'h80000000);
        row(1, 0, 0, 32'h0,          0, 0, 32'h8000000C, 3, 1, 0, 32'h0,        32'h80000000);
        row(1, 0, 0, 32'h0,          0, 0, 32'h80000010, 4, 1, 0, 32'h0,        32'h80000000);
        for (int k = 0; k < 6; k++)
            row(1, 0, 0, 32'h0,      0, 0, 32'h80000010, 4, 1, 0, 32'h0,        32'h80000000);
        // release: push+pop while full, in-order heads, pointers wrap
        row(1, 1, 0, 32'h0,          0, 0, 32'h80000014, 4, 1, 0, 32'h0,        32'h80000004);
        row(1, 1, 0, 32'h0,          0, 0, 32'h80000018, 4, 1, 0, 32'h0,        32'h80000008);
        row(1, 1, 0, 32'h0,          0, 0, 32'h8000001C, 4, 1, 0, 32'h0,        32'h8000000C);
        row(1, 1, 0, 32'h0,          0, 0, 32'h80000020, 4, 1, 0, 32'h0,        32'h80000010);
        // three entries then redirect (concurrent pop discarded)
        row(0, 0, 0, 32'h0,          0, 0, 32'h80000000, 0, 0, 0, 32'h0,        NOCHK);
        row(1, 0, 0, 32'h0,          0, 0, 32'h80000004, 1, 1, 0, 32'h0,        32'h80000000);
        row(1, 0, 0, 32'h0,          0, 0, 32'h80000008, 2, 1, 0, 32'h0,        32'h80000000);
        row(1, 0, 0, 32'h0,          0, 0, 32'h8000000C, 3, 1, 0, 32'h0,        32'h80000000);
        row(1, 1, 1, 32'h00400020,   0, 0, 32'h00400020, 0, 0, 0, 32'h0,        NOCHK);
        row(1, 1, 0, 32'h0,          0, 0, 32'h00400024, 1, 1, 0, 32'h0,        32'h00400020);
        row(1, 0, 0, 32'h0,          0, 0, 32'h00400028, 2, 1, 0, 32'h0,        32'h00400020);
        // user-mode IRQ on queued head; held IRQ ignored in kernel mode
        row(1, 1, 0, 32'h0,          0, 1, 32'h80000004, 0, 0, 1, 32'h00400020, NOCHK);
        row(1, 1, 0, 32'h0,          0, 1, 32'h80000008, 1, 1, 0, 32'h00400020, 32'h80000004);
        row(1, 1, 0, 32'h0,          0, 1, 32'h8000000C, 1, 1, 0, 32'h00400020, 32'h80000008);
        // redirect beats IRQ; then IRQ taken with empty queue (oldest = PC)
        row(1, 1, 1, 32'h00400100,   0, 1, 32'h00400100, 0, 0, 0, 32'h00400020, NOCHK);
        row(1, 0, 0, 32'h0,          0, 1, 32'h80000004, 0, 0, 1, 32'h00400100, NOCHK);
        row(1, 0, 0, 32'h0,          0, 0, 32'h80000008, 1, 1, 0, 32'h00400100, 32'h80000004);
        row(1, 0, 0, 32'h0,          0, 0, 32'h8000000C, 2, 1, 0, 32'h00400100, 32'h80000004);
        // exception beats redirect and IRQ
        row(1, 0, 1, 32'h00400044,   1, 1, 32'h80000008, 0, 0, 0, 32'h00400044, NOCHK);
        row(1, 1, 0, 32'h0,          0, 0, 32'h8000000C, 1, 1, 0, 32'h00400044, 32'h80000008);
        row(1, 0, 0, 32'h0,          0, 0, 32'h80000010, 2, 1, 0, 32'h00400044, 32'h80000008);
        row(1, 0, 0, 32'h0,          0, 0, 32'h80000014, 3, 1, 0, 32'h00400044, 32'h80000008);
        row(1, 0, 0, 32'h0,          0, 0, 32'h80000018, 4, 1, 0, 32'h00400044, 32'h80000008);
        row(1, 0, 0, 32'h0,          0, 0, 32'h80000018, 4, 1, 0, 32'h00400044, 32'h80000008);
        // reset beats redirect with a full queue
        row(0, 1, 1, 32'h00400000,   0, 0, 32'h80000000, 0, 0, 0, 32'h0,        NOCHK);
        row(1, 1, 0, 32'h0,          0, 0, 32'h80000004, 1, 1, 0, 32'h0,        32'h80000000);
        // PC+4 wrap in both segments
        row(1, 0, 1, 32'h7FFFFFFC,   0, 0, 32'h7FFFFFFC, 0, 0, 0, 32'h0,        NOCHK);
        row(1, 1, 0, 32'h0,          0, 0, 32'h00000000, 1, 1, 0, 32'h0,        32'h7FFFFFFC);
        row(1, 0, 1, 32'hFFFFFFFC,   0, 0, 32'hFFFFFFFC, 0, 0, 0, 32'h0,        NOCHK);
        row(1, 1, 0, 32'h0,          0, 0, 32'h80000000, 1, 1, 0, 32'h0,        32'hFFFFFFFC);

        foreach (tbl[i]) begin
            reset          = tbl[i].rst_n;
            id_ready       = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            exc_req        = tbl[i].exc;
            irq            = tbl[i].irq;
            @(posedge clk);
            #1;
            chk($sformatf("r%0d_pc", i),    imem_addr,          tbl[i].pc);
            chk($sformatf("r%0d_cnt", i),   32'(fq_count),      32'(tbl[i].cnt));
            chk($sformatf("r%0d_vld", i),   32'(id_valid),      32'(tbl[i].vld));
            chk($sformatf("r%0d_take", i),  32'(irq_take),      32'(tbl[i].take));
            chk($sformatf("r%0d_epc", i),   epc,                tbl[i].epc);
            if (tbl[i].hpc != NOCHK) begin
                chk($sformatf("r%0d_hpc", i),   id_pc,      tbl[i].hpc);
                chk($sformatf("r%0d_instr", i), id_instr,   ~tbl[i].hpc);
                chk($sformatf("r%0d_pp4", i),   id_pcplus4, pc4(tbl[i].hpc));
            end
        end

        // Streamed run from reset with random decode readiness.
        reset = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; exc_req = 1'b0; irq = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 24; k++) sb_q.push_back(32'h80000000 + 32'(4 * k));
        sb_run(300);

        // Mid-stream redirect: everything queued is dropped, stream restarts at the target.
        @(posedge clk);
        #1;
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h00400200;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        chk("sb_flush_cnt", 32'(fq_count), 32'd0);
        chk("sb_flush_pc", imem_addr, 32'h00400200);
        for (int k = 0; k < 16; k++) sb_q.push_back(32'h00400200 + 32'(4 * k));
        sb_run(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
